// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_pkg
//  Description : Shared types and constants for the TinyALU round-robin
//                controller: FSM state encoding, opcode values and the
//                fixed result words returned without running the ALU.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic [2:0]  OP_NOP = 3'b000;
    localparam logic [2:0]  OP_ADD = 3'b001;
    localparam logic [2:0]  OP_AND = 3'b010;
    localparam logic [2:0]  OP_XOR = 3'b011;

    localparam logic [15:0] NOP_RESULT     = 16'h0000;
    localparam logic [15:0] TIMEOUT_RESULT = 16'hDEAD;

    // Only the all-zero opcode bypasses the ALU; 3'b100 still goes to the
    // ALU because it produces a done pulse for it.
    function automatic logic is_nop(input logic [2:0] op);
        return (op == OP_NOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin selector. Searches the
//                request vector starting at i_ptr and wrapping, and returns
//                the first active index. The pointer register lives in the
//                parent.
//  Ports       : i_req       - request vector
//                i_ptr       - highest-priority index for this search
//                o_grant     - one-hot grant (zero when nothing requests)
//                o_grant_idx - binary index of the grant
//                o_grant_any - at least one request is active
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_any
);

    int w_idx;

    // Walk from the farthest offset to the nearest one; each hit overwrites
    // the previous, so the index closest to i_ptr wins without a break.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_idx       = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_idx = (int'(i_ptr) + off) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = IDX_W'(w_idx);
                o_grant_any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one single-cycle TinyALU among NUM_REQ requesters.
//                Accepts one request at a time (round-robin), starts the
//                ALU, waits for its registered done, and returns the 16-bit
//                result on a per-requester valid/ready response channel.
//                NOP requests are answered directly without the ALU.
//  Build macro : ALU_ARB_TIMEOUT_EN - enables a WAIT-state watchdog that
//                answers 16'hDEAD with resp_err=1 after TIMEOUT_CYCLES.
//  Ports       : clk, rst_n (async, active-low)
//                req_valid/req_ready/req_op/req_a/req_b - request channel
//                resp_valid/resp_ready/resp_result/resp_err - response
//                alu_start/alu_op/alu_a/alu_b - ALU issue
//                alu_done/alu_result - ALU completion
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][2:0]  req_op,
    input  logic [NUM_REQ-1:0][7:0]  req_a,
    input  logic [NUM_REQ-1:0][7:0]  req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [15:0]              resp_result,
    output logic                     resp_err,
    output logic                     alu_start,
    output logic [2:0]               alu_op,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    input  logic                     alu_done,
    input  logic [15:0]              alu_result
);

    import alu_arb_pkg::*;

    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e           r_state;
    arb_state_e           w_state_next;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   r_gnt_idx;
    logic [2:0]           r_op;
    logic [7:0]           r_a;
    logic [7:0]           r_b;
    logic [15:0]          r_result;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_idx_w-1:0]   w_grant_idx;
    logic                 w_grant_any;
    logic [2:0]           w_sel_op;
    logic                 w_resp_hs;
    logic                 w_timeout;
    logic [NUM_REQ-1:0]   w_resp_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_arbiter (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    assign w_sel_op  = req_op[w_grant_idx];
    assign w_resp_hs = (r_state == ST_RESP) && resp_ready[r_gnt_idx];

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_tmr_w-1:0] r_timer;
    logic               r_err;

    // Timer counts 0..TIMEOUT_CYCLES-1 across WAIT; the last count is the
    // TIMEOUT_CYCLES-th WAIT cycle, after which the watchdog fires.
    assign w_timeout = (r_state == ST_WAIT) &&
                       (r_timer == c_tmr_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_timer <= '0;
            end else if ((r_state == ST_WAIT) && !w_timeout) begin
                r_timer <= r_timer + c_tmr_w'(1);
            end
            // A done arriving together with expiry is a normal completion.
            if (w_timeout && !alu_done) begin
                r_err <= 1'b1;
            end else if (w_resp_hs) begin
                r_err <= 1'b0;
            end
        end
    end

    assign resp_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign resp_err  = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_state_next = is_nop(w_sel_op) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_done || w_timeout) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_resp_hs) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_gnt_idx <= w_grant_idx;
                        r_op      <= w_sel_op;
                        r_a       <= req_a[w_grant_idx];
                        r_b       <= req_b[w_grant_idx];
                        if (is_nop(w_sel_op)) begin
                            r_result <= NOP_RESULT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        r_result <= alu_result;
                    end else if (w_timeout) begin
                        r_result <= TIMEOUT_RESULT;
                    end
                end
                ST_RESP: begin
                    if (w_resp_hs) begin
                        r_rr_ptr <= (r_gnt_idx == c_idx_w'(NUM_REQ - 1)) ?
                                    '0 : (r_gnt_idx + c_idx_w'(1));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        w_resp_valid = '0;
        if (r_state == ST_RESP) begin
            w_resp_valid[r_gnt_idx] = 1'b1;
        end
    end

    // Gating with rst_n keeps req_ready low while reset is held even if
    // requesters leave req_valid asserted.
    assign req_ready   = ((r_state == ST_IDLE) && rst_n) ? w_grant : '0;
    assign resp_valid  = w_resp_valid;
    assign resp_result = r_result;
    assign alu_start   = (r_state == ST_ISSUE);
    assign alu_op      = r_op;
    assign alu_a       = r_a;
    assign alu_b       = r_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter with a
//                behavioural TinyALU (done/result registered one cycle after
//                start) and a scoreboard of expected responses.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N = 4;

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][2:0]   req_op;
    logic [N-1:0][7:0]   req_a;
    logic [N-1:0][7:0]   req_b;
    logic [N-1:0]        resp_valid;
    logic [N-1:0]        resp_ready;
    logic [15:0]         resp_result;
    logic                resp_err;
    logic                alu_start;
    logic [2:0]          alu_op;
    logic [7:0]          alu_a;
    logic [7:0]          alu_b;
    logic                alu_done;
    logic [15:0]         alu_result;

    logic                model_done   = 1'b0;
    logic [15:0]         model_result = 16'h0000;
    logic                alu_block;
    logic                force_done;

    exp_t                q[$];
    int                  total = 0;
    int                  bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_done    (alu_done),
        .alu_result  (alu_result)
    );

    function automatic logic [15:0] alu_ref(input logic [2:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        case (op[1:0])
            2'b01:   return {8'h00, a} + {8'h00, b};
            2'b10:   return {8'h00, a & b};
            2'b11:   return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural TinyALU: registered done one cycle after start.
    always @(posedge clk) begin
        model_done <= alu_start && !alu_block;
        if (alu_start) model_result <= alu_ref(alu_op, alu_a, alu_b);
    end
    assign alu_done   = model_done | force_done;
    assign alu_result = force_done ? 16'hBEEF : model_result;

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        req_valid[i] = 1'b1;
        req_op[i]    = op;
        req_a[i]     = a;
        req_b[i]     = b;
    endtask

    task automatic wait_grant(input string tag, input int i);
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 40) begin
            cyc();
            n++;
        end
        chk(tag, 32'(req_ready), 32'(oh(i)));
    endtask

    task automatic wait_resp(input string tag, input int stall);
        exp_t e;
        int   n;
        n = 0;
        while (resp_valid == '0 && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_sb_depth"}, 32'(q.size()), 32'd1);
        if (q.size() > 0) e = q.pop_front();
        else              e = '{idx: 0, res: 16'h0000, err: 1'b0};
        chk({tag, "_valid"},  32'(resp_valid),  32'(oh(e.idx)));
        chk({tag, "_result"}, 32'(resp_result), 32'(e.res));
        chk({tag, "_err"},    32'(resp_err),    32'(e.err));
        for (int s = 0; s < stall; s++) begin
            cyc();
            chk({tag, "_hold_valid"},  32'(resp_valid),  32'(oh(e.idx)));
            chk({tag, "_hold_result"}, 32'(resp_result), 32'(e.res));
            chk({tag, "_hold_ready"},  32'(req_ready),   32'd0);
            chk({tag, "_hold_start"},  32'(alu_start),   32'd0);
        end
        resp_ready = oh(e.idx);
        cyc();
        resp_ready = '0;
        chk({tag, "_drop"},     32'(resp_valid), 32'd0);
        chk({tag, "_err_clr"},  32'(resp_err),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '0;
        alu_block  = 1'b0;
        force_done = 1'b0;
        cyc();
        cyc();

        // Reset values
        chk("rst_req_ready",   32'(req_ready),   32'd0);
        chk("rst_resp_valid",  32'(resp_valid),  32'd0);
        chk("rst_alu_start",   32'(alu_start),   32'd0);
        chk("rst_resp_err",    32'(resp_err),    32'd0);
        chk("rst_resp_result", 32'(resp_result), 32'd0);
        chk("rst_alu_op",      32'(alu_op),      32'd0);
        chk("rst_alu_a",       32'(alu_a),       32'd0);
        chk("rst_alu_b",       32'(alu_b),       32'd0);
        rst_n = 1'b1;
        cyc();

        // Round robin, all four XOR: grants 0,1,2,3 then 0 again
        for (int i = 0; i < N; i++) drive(i, 3'b011, 8'(i), 8'h0F);
        for (int n = 0; n < 5; n++) begin
            int k;
            k = n % N;
            wait_grant("rr_grant", k);
            q.push_back('{idx: k, res: {8'h00, 8'(k) ^ 8'h0F}, err: 1'b0});
            cyc();
            req_valid[k] = 1'b0;
            chk("rr_start", 32'(alu_start), 32'd1);
            chk("rr_op",    32'(alu_op),    32'd3);
            chk("rr_a",     32'(alu_a),     32'(k));
            wait_resp("rr", 0);
            if (n == 0) drive(0, 3'b011, 8'h00, 8'h0F);
        end

        // ADD latency: ready@0, start@1, resp@3, 0xFF+0x01 = 0x0100
        drive(1, 3'b001, 8'hFF, 8'h01);
        #1;
        chk("add_ready_c0", 32'(req_ready), 32'(oh(1)));
        q.push_back('{idx: 1, res: 16'h0100, err: 1'b0});
        cyc();
        req_valid = '0;
        chk("add_start_c1", 32'(alu_start), 32'd1);
        chk("add_a_c1",     32'(alu_a),     32'hFF);
        chk("add_b_c1",     32'(alu_b),     32'h01);
        chk("add_ready_c1", 32'(req_ready), 32'd0);
        cyc();
        chk("add_start_c2", 32'(alu_start),  32'd0);
        chk("add_resp_c2",  32'(resp_valid), 32'd0);
        cyc();
        chk("add_resp_c3",  32'(resp_valid), 32'(oh(1)));
        wait_resp("add", 0);

        // NOP on requester 2: response at cycle 1, ALU untouched
        drive(2, 3'b000, 8'h05, 8'h07);
        #1;
        chk("nop_ready", 32'(req_ready), 32'(oh(2)));
        q.push_back('{idx: 2, res: 16'h0000, err: 1'b0});
        cyc();
        req_valid = '0;
        chk("nop_resp_c1",  32'(resp_valid), 32'(oh(2)));
        chk("nop_no_start", 32'(alu_start),  32'd0);
        wait_resp("nop", 0);

        // Back-pressure: resp_ready low for 5 cycles, requester 0 waiting
        drive(3, 3'b010, 8'hF0, 8'h3C);
        drive(0, 3'b100, 8'h12, 8'h34);
        wait_grant("stall_grant", 3);
        q.push_back('{idx: 3, res: 16'h0030, err: 1'b0});
        cyc();
        req_valid[3] = 1'b0;
        wait_resp("stall", 5);
        chk("post_hs_grant", 32'(req_ready), 32'(oh(0)));
        q.push_back('{idx: 0, res: 16'h0000, err: 1'b0});
        cyc();
        req_valid[0] = 1'b0;
        chk("op4_passthru", 32'(alu_op), 32'h4);
        wait_resp("op4", 0);

        // Reset during WAIT aborts; first grant afterwards goes to 0
        drive(0, 3'b001, 8'h03, 8'h04);
        drive(2, 3'b010, 8'h3C, 8'h0F);
        wait_grant("pre_rst_grant", 2);
        cyc();
        req_valid[2] = 1'b0;
        chk("pre_rst_start", 32'(alu_start), 32'd1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready",  32'(req_ready),   32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid),  32'd0);
        chk("mid_rst_alu_start",  32'(alu_start),   32'd0);
        chk("mid_rst_alu_op",     32'(alu_op),      32'd0);
        chk("mid_rst_alu_a",      32'(alu_a),       32'd0);
        chk("mid_rst_result",     32'(resp_result), 32'd0);
        req_valid[2] = 1'b1;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'(oh(0)));
        q.push_back('{idx: 0, res: 16'h0007, err: 1'b0});
        cyc();
        req_valid[0] = 1'b0;
        wait_resp("post_rst0", 0);
        wait_grant("post_rst_grant2", 2);
        q.push_back('{idx: 2, res: 16'h000C, err: 1'b0});
        cyc();
        req_valid[2] = 1'b0;
        wait_resp("post_rst2", 0);

        // Spurious done in IDLE is ignored
        force_done = 1'b1;
        cyc();
        force_done = 1'b0;
        chk("spur_resp_valid", 32'(resp_valid),  32'd0);
        chk("spur_alu_start",  32'(alu_start),   32'd0);
        chk("spur_result",     32'(resp_result), 32'h000C);
        drive(3, 3'b011, 8'h55, 8'hAA);
        wait_grant("spur_next_grant", 3);
        q.push_back('{idx: 3, res: 16'h00FF, err: 1'b0});
        cyc();
        req_valid[3] = 1'b0;
        wait_resp("spur_next", 0);

`ifdef ALU_ARB_TIMEOUT_EN
        // Watchdog: no done -> 0xDEAD with err after 15 WAIT cycles
        alu_block = 1'b1;
        drive(1, 3'b001, 8'h01, 8'h01);
        wait_grant("tmo_grant", 1);
        q.push_back('{idx: 1, res: 16'hDEAD, err: 1'b1});
        cyc();
        req_valid[1] = 1'b0;
        chk("tmo_start", 32'(alu_start), 32'd1);
        repeat (15) cyc();
        chk("tmo_not_yet", 32'(resp_valid), 32'd0);
        cyc();
        chk("tmo_fire", 32'(resp_valid), 32'(oh(1)));
        wait_resp("tmo", 0);
        alu_block = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
